mult_8x8_seq_ctrl: RTL and testbench

//  Area-reduced 8x8 unsigned multiplier: one shared 4x4 core computes all four nibble partial products in turn.

---
 rtl/mult_8x8_seq_ctrl_pkg.sv | 7 +
 rtl/mult_8x8_seq_ctrl_approx.sv | 8 +
 rtl/mult_8x8_seq_ctrl.sv | 93 +++++++++
 tb/tb_mult_8x8_seq_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mult_8x8_seq_ctrl_pkg.sv
// mult_pkg: shared state encoding and partial-product shift amounts
package mult_pkg;
  typedef enum logic [2:0] {IDLE, LL, HL, LH, HH, DONE} state_e;
  localparam int SH_LL  = 0;
  localparam int SH_MID = 4;
  localparam int SH_HH  = 8;
endpackage

// File: rtl/mult_8x8_seq_ctrl_approx.sv
// mult_approx: shared 4x4 unsigned multiplier core
module mult_approx (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] prod
);
  assign prod = {4'b0, a} * {4'b0, b};
endmodule

// File: rtl/mult_8x8_seq_ctrl.sv
// mult_8x8_seq_ctrl: 8x8 unsigned multiplier built from one 4x4 core stepped over four nibble products
module mult_8x8_seq_ctrl
  import mult_pkg::*;
#(
  parameter bit SKIP_LL = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      prod,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  state_e           state_q, state_d;
  logic [7:0]       a_q, a_d, b_q, b_d;
  logic [15:0]      acc_q, acc_d, prod_q, prod_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [3:0]       core_a, core_b;
  logic [7:0]       core_p;
  logic [15:0]      term;
  logic             accept, out_hs;

  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign in_ready  = (state_q == IDLE) | (out_valid & out_ready);
  assign prod      = prod_q;
  assign op_count  = op_count_q;
  assign accept    = in_valid & in_ready & ~flush;
  assign out_hs    = out_valid & out_ready & ~flush;

  mult_approx u_core (.a(core_a), .b(core_b), .prod(core_p));

  // Nibble select and shift of the current partial product
  always_comb begin
    core_a = (state_q == HL || state_q == HH) ? a_q[7:4] : a_q[3:0];
    core_b = (state_q == LH || state_q == HH) ? b_q[7:4] : b_q[3:0];
    term   = (state_q == LL) ? {8'b0, core_p} << SH_LL :
             (state_q == HH) ? {8'b0, core_p} << SH_HH : {8'b0, core_p} << SH_MID;
  end

  // Next-state, accumulate and operand capture; flush wins over everything
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    prod_d     = prod_q;
    op_count_d = op_count_q + CNT_W'(out_hs);
    case (state_q)
      LL: begin acc_d = acc_q + term; state_d = HL; end
      HL: begin acc_d = acc_q + term; state_d = LH; end
      LH: begin acc_d = acc_q + term; state_d = HH; end
      HH: begin prod_d = acc_q + term; acc_d = acc_q + term; state_d = DONE; end
      default: state_d = (state_q == DONE && out_ready) ? IDLE : state_q;
    endcase
    if (accept) begin
      a_d     = a;
      b_d     = b;
      acc_d   = '0;
      state_d = SKIP_LL ? HL : LL;
    end
    if (flush) begin
      state_d = IDLE;
      acc_d   = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      prod_q     <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      prod_q     <= prod_d;
      op_count_q <= op_count_d;
    end
  end
endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// tb_mult_8x8_seq_ctrl: directed checks of the exact and LL-skipping sequential multiplier
module tb_mult_8x8_seq_ctrl;
  logic        clk = 0, rst_n = 0, flush = 0;
  logic        iv0 = 0, ir0, or0 = 0, ov0, busy0;
  logic [7:0]  a0 = 0, b0 = 0;
  logic [15:0] p0, cnt0;
  logic        iv1 = 0, ir1, or1 = 0, ov1, busy1;
  logic [7:0]  a1 = 0, b1 = 0;
  logic [15:0] p1;
  logic [1:0]  cnt1;
  int cmp = 0, err = 0;

  mult_8x8_seq_ctrl #(.SKIP_LL(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .out_valid(ov0), .out_ready(or0), .prod(p0), .busy(busy0), .op_count(cnt0));

  mult_8x8_seq_ctrl #(.SKIP_LL(1'b1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1), .prod(p1), .busy(busy1), .op_count(cnt1));

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    rst_n = 0;
    #1;
    rst_n = 1;
    tick;
  endtask

  task op0(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input int lat);
    int n;
    or0 = 1; a0 = a; b0 = b; iv0 = 1;
    n = 0;
    while (!ir0 && n < 10) begin tick; n++; end
    tick;
    iv0 = 0; a0 = ~a; b0 = ~b;
    n = 0;
    while (!ov0 && n < 10) begin tick; n++; end
    cmp++; if (n !== lat) begin err++; $display("FAIL op0_latency %h*%h: got %0d want %0d", a, b, n, lat); end
    cmp++; if (p0 !== exp) begin err++; $display("FAIL op0_prod %h*%h: got %h want %h", a, b, p0, exp); end
    tick;
    cmp++; if (ov0 !== 1'b0) begin err++; $display("FAIL op0_drop_valid: got %b want 0", ov0); end
  endtask

  task op1(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input logic [1:0] exp_cnt);
    int n;
    or1 = 1; a1 = a; b1 = b; iv1 = 1;
    n = 0;
    while (!ir1 && n < 10) begin tick; n++; end
    tick;
    iv1 = 0; a1 = ~a; b1 = ~b;
    n = 0;
    while (!ov1 && n < 10) begin tick; n++; end
    cmp++; if (n !== 3) begin err++; $display("FAIL skip_latency %h*%h: got %0d want 3", a, b, n); end
    cmp++; if (p1 !== exp) begin err++; $display("FAIL skip_prod %h*%h: got %h want %h", a, b, p1, exp); end
    tick;
    cmp++; if (cnt1 !== exp_cnt) begin err++; $display("FAIL skip_count: got %0d want %0d", cnt1, exp_cnt); end
  endtask

  task test_reset;
    repeat (2) tick;
    cmp++; if ({ov0, busy0, p0, cnt0} !== 34'b0) begin err++; $display("FAIL reset_state: got ov=%b busy=%b prod=%h cnt=%h want all 0", ov0, busy0, p0, cnt0); end
    rst_n = 1;
    tick;
    cmp++; if ({ir0, busy0} !== 2'b10) begin err++; $display("FAIL reset_ready: got ready=%b busy=%b want 1 0", ir0, busy0); end
  endtask

  task test_max;
    op0(8'hFF, 8'hFF, 16'hFE01, 4);
    cmp++; if (cnt0 !== 16'd1) begin err++; $display("FAIL max_count: got %0d want 1", cnt0); end
  endtask

  task test_basic;
    do_reset;
    op0(8'h12, 8'h34, 16'h03A8, 4);
    op0(8'h00, 8'hAB, 16'h0000, 4);
    cmp++; if (cnt0 !== 16'd2) begin err++; $display("FAIL basic_count: got %0d want 2", cnt0); end
  endtask

  task test_stall;
    int n;
    or0 = 0; a0 = 8'h0A; b0 = 8'h0B; iv0 = 1;
    tick;
    iv0 = 0;
    n = 0;
    while (!ov0 && n < 10) begin tick; n++; end
    repeat (6) begin
      tick;
      cmp++; if ({ov0, ir0, p0} !== {2'b10, 16'h006E}) begin err++; $display("FAIL stall_hold: got ov=%b ready=%b prod=%h want 1 0 006e", ov0, ir0, p0); end
    end
    cmp++; if (cnt0 !== 16'd2) begin err++; $display("FAIL stall_count: got %0d want 2", cnt0); end
    or0 = 1;
    tick;
    cmp++; if ({ov0, cnt0} !== {1'b0, 16'd3}) begin err++; $display("FAIL stall_release: got ov=%b cnt=%0d want 0 3", ov0, cnt0); end
  endtask

  task test_back_to_back;
    logic [7:0]  ea [3];
    logic [7:0]  eb [3];
    logic [15:0] ep [3];
    int k, t, last;
    ea = '{8'h03, 8'h10, 8'hFF}; eb = '{8'h05, 8'h10, 8'h02}; ep = '{16'h000F, 16'h0100, 16'h01FE};
    or0 = 1; iv0 = 1; a0 = ea[0]; b0 = eb[0];
    tick;
    k = 0; t = 0; last = 0;
    while (k < 3 && t < 40) begin
      tick; t++;
      if (ov0) begin
        cmp++; if (p0 !== ep[k]) begin err++; $display("FAIL b2b_prod[%0d]: got %h want %h", k, p0, ep[k]); end
        if (k > 0) begin
          cmp++; if (t - last !== 5) begin err++; $display("FAIL b2b_spacing[%0d]: got %0d want 5", k, t - last); end
        end
        last = t; k++;
        if (k < 3) begin a0 = ea[k]; b0 = eb[k]; end else iv0 = 0;
      end
    end
    cmp++; if (k !== 3) begin err++; $display("FAIL b2b_timeout: got %0d results want 3", k); end
    tick;
    cmp++; if ({ov0, cnt0} !== {1'b0, 16'd6}) begin err++; $display("FAIL b2b_end: got ov=%b cnt=%0d want 0 6", ov0, cnt0); end
  endtask

  task test_skip;
    do_reset;
    op1(8'h1F, 8'h1F, 16'h02E0, 2'd1);
    op1(8'h0F, 8'h0F, 16'h0000, 2'd2);
    op1(8'h20, 8'h03, 16'h0060, 2'd3);
    op1(8'h11, 8'h11, 16'h0120, 2'd0);
  endtask

  task test_abort;
    logic seen;
    do_reset;
    or0 = 1; a0 = 8'h55; b0 = 8'h66; iv0 = 1;
    tick;
    iv0 = 0;
    repeat (2) tick;
    cmp++; if ({busy0, ov0} !== 2'b10) begin err++; $display("FAIL abort_midop: got busy=%b ov=%b want 1 0", busy0, ov0); end
    rst_n = 0;
    #1;
    cmp++; if ({ov0, busy0, cnt0, p0} !== 34'b0) begin err++; $display("FAIL abort_reset: got ov=%b busy=%b cnt=%h prod=%h want all 0", ov0, busy0, cnt0, p0); end
    rst_n = 1;
    seen = 0;
    repeat (6) begin tick; seen |= ov0; end
    cmp++; if (seen !== 1'b0) begin err++; $display("FAIL abort_reset_output: got %b want 0", seen); end
    op0(8'h03, 8'h04, 16'h000C, 4);
    a0 = 8'h77; b0 = 8'h88; iv0 = 1;
    tick;
    iv0 = 0;
    tick;
    flush = 1;
    tick;
    flush = 0;
    cmp++; if ({busy0, ov0} !== 2'b00) begin err++; $display("FAIL flush_idle: got busy=%b ov=%b want 0 0", busy0, ov0); end
    seen = 0;
    repeat (6) begin tick; seen |= ov0; end
    cmp++; if ({seen, cnt0, p0} !== {1'b0, 16'd1, 16'h000C}) begin err++; $display("FAIL flush_after: got ov_seen=%b cnt=%0d prod=%h want 0 1 000c", seen, cnt0, p0); end
  endtask

  initial begin
    test_reset;
    test_max;
    test_basic;
    test_stall;
    test_back_to_back;
    test_skip;
    test_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
